alu_control_pipe: RTL and testbench
===================================

Name: alu_control_pipe

Overview:
- Registered, parametrised ALU control decoder for the MIPS datapath.
- Decodes a 2-bit ALU-op class plus funct/opcode into an ALU control word.
- Extends the base add/sub/and/or/slt set with xor, nor, sltu, shifts and I-type logicals.
- Sequences multi-cycle mult/div operations, with a stall interlock and a HI/LO write-enable pulse.
- Sits between the main control unit and the ALU / mult-div unit. Adds one register stage.

Parameters:
- CTRL_W, 4: width of the control output. Must be >= 4; bits above [3:0] are driven 0.
- MULDIV_LAT, 8: number of BUSY cycles for mult/div. Must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  decode request this cycle.
- aluop  input  2  class: 00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- funct  input  6  instruction funct field; used when aluop=10.
- opcode  input  6  instruction opcode; used when aluop=11.
- control  output  CTRL_W  registered ALU control word.
- shamt_sel  output  1  1 = shift amount comes from the shamt field.
- illegal  output  1  registered: unsupported funct/opcode.
- valid_out  output  1  registered: a decode was accepted last cycle.
- stall  output  1  mult/div in progress; upstream must hold and not issue.
- muldiv_start  output  1  one-cycle start pulse to the mult/div unit.
- muldiv_op  output  2  00 mult, 01 multu, 10 div, 11 divu.
- hilo_we  output  1  one-cycle HI/LO write enable.

Behaviour:
- Control encodings:
  - AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, SLTU 1000.
  - SLL 1001, SRL 1010, SRA 1011, NOR 1100.
- Decode by aluop:
  - aluop=00: ADD.
  - aluop=01: SUB.
  - aluop=10, by funct:
    - 100000/100001 ADD; 100010/100011 SUB; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR; 101010 SLT; 101011 SLTU.
    - 000000 SLL, 000010 SRL, 000011 SRA, all with shamt_sel=1.
    - 000100 SLL, 000110 SRL, 000111 SRA, all with shamt_sel=0.
    - 011000-011011 are mult/div.
  - aluop=11, by opcode: 001000/001001 ADD; 001100 AND; 001101 OR; 001110 XOR; 001010 SLT; 001011 SLTU.
  - Any other funct/opcode: control=0, shamt_sel=0, illegal=1.
- Latency and hold:
  - A request is accepted when valid_in=1 and stall=0.
  - Outputs control, shamt_sel, illegal and muldiv_op update one clock after acceptance.
  - On that same edge, valid_out=1 for one cycle.
  - With no acceptance, those outputs hold their value and valid_out=0.
- Mult/div FSM, states IDLE, BUSY, DONE:
  - IDLE -> BUSY: on acceptance of a mult/div funct at edge T.
  - At T+1: muldiv_start=1 for one cycle, muldiv_op=funct[1:0], control=0, illegal=0, counter loaded with MULDIV_LAT-1.
  - BUSY: counter decrements each cycle. When counter=0, next state is DONE. BUSY lasts exactly MULDIV_LAT cycles (T+1 .. T+MULDIV_LAT).
  - DONE: one cycle at T+MULDIV_LAT+1 with hilo_we=1. Next state is IDLE.
  - stall=1 in BUSY and DONE, 0 in IDLE. stall is combinational from the state.
  - valid_in is ignored while stall=1; no outputs change except the FSM outputs.
- Counter width: $clog2(MULDIV_LAT+1).
- Reset values: control=0, shamt_sel=0, illegal=0, valid_out=0, muldiv_start=0, muldiv_op=0, hilo_we=0, state=IDLE, counter=0.
- Reset mid-operation (BUSY or DONE): next cycle is IDLE, stall=0, no hilo_we pulse, no pending start.
- Back-to-back mult/div: a second mult/div presented while stalled is not accepted. It is accepted the cycle after DONE, when stall=0.

Optional Feature:
- Macro: ALU_CTRL_MULDIV_EN.
- Defined: mult/div decode, FSM, counter, stall, muldiv_start, muldiv_op and hilo_we behave as above.
- Undefined: FSM and counter are not built. stall, muldiv_start and hilo_we are tied 0; muldiv_op is tied 00. Funct 011000-011011 decode as illegal (control=0, illegal=1).
- Port list is identical in both builds.

Test Plan:
- Reset, then valid_in=1, aluop=10, funct=100010 -> next cycle: control=0110, valid_out=1, illegal=0. Following cycle with valid_in=0: valid_out=0, control holds 0110.
- aluop=10, funct=000011 -> control=1011, shamt_sel=1. Then funct=000111 -> control=1011, shamt_sel=0. Then aluop=11, opcode=001110 -> control=0011.
- aluop=10, funct=111111 -> control=0000, illegal=1. Then aluop=00 -> control=0010, illegal=0.
- MULDIV_LAT=3, funct=011010 accepted at T:
  - T+1: muldiv_start=1, muldiv_op=10.
  - T+1..T+4: stall=1; hilo_we=1 only at T+4.
  - T+5: stall=0.
  - An ADD held on the inputs from T+1 is accepted at edge T+5; control=0010 at T+6.
- MULDIV_LAT=8, mult accepted, reset asserted at T+4 -> T+5: stall=0, hilo_we never pulses, all outputs at reset values.
- Build without ALU_CTRL_MULDIV_EN: funct=011000 -> illegal=1, stall=0, muldiv_start=0.

Source files
------------

// File: rtl/alu_control_pipe.sv
// -----------------------------------------------------------------------------
// alu_control_pipe
//
// Registered ALU control decoder for the MIPS datapath. It takes the 2-bit
// ALU-op class from the main control unit, plus the funct or opcode field. It
// produces the ALU control word one clock later. It also sequences multi-cycle
// mult/div operations. While a mult/div is in flight it raises a stall
// interlock toward the issue stage. It pulses a HI/LO write enable when the
// operation completes.
//
// Optional feature macro: ALU_CTRL_MULDIV_EN
//   defined   : mult/div decode, IDLE/BUSY/DONE sequencer, stall, start pulse,
//               muldiv_op and hilo_we are built.
//   undefined : no sequencer is built. stall, muldiv_start and hilo_we are
//               tied low and muldiv_op is tied 00. funct 011000-011011 decode
//               as illegal.
//
// Parameters
//   CTRL_W      width of the control word (>= 4, upper bits driven 0)
//   MULDIV_LAT  number of BUSY cycles for a mult/div (>= 1)
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high reset
//   valid_in      in   decode request this cycle
//   aluop[1:0]    in   00 load/store, 01 branch, 10 R-type, 11 I-type ALU
//   funct[5:0]    in   funct field (used when aluop=10)
//   opcode[5:0]   in   opcode field (used when aluop=11)
//   control       out  registered ALU control word
//   shamt_sel     out  1 = shift amount taken from the shamt field
//   illegal       out  registered: unsupported funct/opcode
//   valid_out     out  registered: a decode was accepted last cycle
//   stall         out  mult/div in progress, upstream must hold
//   muldiv_start  out  one-cycle start pulse to the mult/div unit
//   muldiv_op     out  00 mult, 01 multu, 10 div, 11 divu
//   hilo_we       out  one-cycle HI/LO write enable
// -----------------------------------------------------------------------------
module alu_control_pipe #(
  parameter int CTRL_W     = 4,
  parameter int MULDIV_LAT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [1:0]        aluop,
  input  logic [5:0]        funct,
  input  logic [5:0]        opcode,
  output logic [CTRL_W-1:0] control,
  output logic              shamt_sel,
  output logic              illegal,
  output logic              valid_out,
  output logic              stall,
  output logic              muldiv_start,
  output logic [1:0]        muldiv_op,
  output logic              hilo_we
);

  // ALU control encodings
  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_XOR  = 4'b0011;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_SLTU = 4'b1000;
  localparam logic [3:0] CTRL_SLL  = 4'b1001;
  localparam logic [3:0] CTRL_SRL  = 4'b1010;
  localparam logic [3:0] CTRL_SRA  = 4'b1011;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;

  logic [3:0] w_ctrl;
  logic       w_shamt;
  logic       w_illegal;
  logic       w_accept;

  logic [3:0] r_ctrl;
  logic       r_shamt;
  logic       r_illegal;
  logic       r_valid_out;

`ifdef ALU_CTRL_MULDIV_EN
  logic       w_is_muldiv;
`endif

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_ctrl      = CTRL_AND;
    w_shamt     = 1'b0;
    w_illegal   = 1'b0;
`ifdef ALU_CTRL_MULDIV_EN
    w_is_muldiv = 1'b0;
`endif
    unique case (aluop)
      2'b00: w_ctrl = CTRL_ADD;
      2'b01: w_ctrl = CTRL_SUB;
      2'b10: begin
        case (funct)
          6'b100000, 6'b100001: w_ctrl = CTRL_ADD;
          6'b100010, 6'b100011: w_ctrl = CTRL_SUB;
          6'b100100:            w_ctrl = CTRL_AND;
          6'b100101:            w_ctrl = CTRL_OR;
          6'b100110:            w_ctrl = CTRL_XOR;
          6'b100111:            w_ctrl = CTRL_NOR;
          6'b101010:            w_ctrl = CTRL_SLT;
          6'b101011:            w_ctrl = CTRL_SLTU;
          6'b000000: begin w_ctrl = CTRL_SLL; w_shamt = 1'b1; end
          6'b000010: begin w_ctrl = CTRL_SRL; w_shamt = 1'b1; end
          6'b000011: begin w_ctrl = CTRL_SRA; w_shamt = 1'b1; end
          6'b000100:            w_ctrl = CTRL_SLL;
          6'b000110:            w_ctrl = CTRL_SRL;
          6'b000111:            w_ctrl = CTRL_SRA;
          // mult/multu/div/divu: the ALU itself idles (control 0).
          6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
`ifdef ALU_CTRL_MULDIV_EN
            w_is_muldiv = 1'b1;
`else
            w_illegal   = 1'b1;
`endif
          end
          default:              w_illegal = 1'b1;
        endcase
      end
      2'b11: begin
        case (opcode)
          6'b001000, 6'b001001: w_ctrl = CTRL_ADD;
          6'b001100:            w_ctrl = CTRL_AND;
          6'b001101:            w_ctrl = CTRL_OR;
          6'b001110:            w_ctrl = CTRL_XOR;
          6'b001010:            w_ctrl = CTRL_SLT;
          6'b001011:            w_ctrl = CTRL_SLTU;
          default:              w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // A request is taken only when the interlock is down.
  assign w_accept = valid_in & ~stall;

  // ---------------------------------------------------------------------------
  // Decode output register: updates only on acceptance, otherwise holds.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl      <= 4'b0000;
      r_shamt     <= 1'b0;
      r_illegal   <= 1'b0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= w_accept;
      if (w_accept) begin
        r_ctrl    <= w_ctrl;
        r_shamt   <= w_shamt;
        r_illegal <= w_illegal;
      end
    end
  end

  assign control   = CTRL_W'(r_ctrl);
  assign shamt_sel = r_shamt;
  assign illegal   = r_illegal;
  assign valid_out = r_valid_out;

`ifdef ALU_CTRL_MULDIV_EN
  // ---------------------------------------------------------------------------
  // Mult/div sequencer
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } md_state_t;

  localparam int              CNT_W    = $clog2(MULDIV_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

  md_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_start;
  logic             r_hilo_we;
  logic [1:0]       r_md_op;

  // Start and HI/LO pulses are registered alongside the state transition that
  // produces them. They are therefore high in exactly the first BUSY cycle and
  // in the single DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_start   <= 1'b0;
      r_hilo_we <= 1'b0;
      r_md_op   <= 2'b00;
    end else begin
      r_start   <= 1'b0;
      r_hilo_we <= 1'b0;
      if (w_accept) begin
        r_md_op <= w_is_muldiv ? funct[1:0] : 2'b00;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_muldiv) begin
            r_state <= S_BUSY;
            r_cnt   <= CNT_LOAD;
            r_start <= 1'b1;
          end
        end
        S_BUSY: begin
          // The load value is LAT-1 and we leave on zero, so BUSY spans LAT cycles.
          if (r_cnt == '0) begin
            r_state   <= S_DONE;
            r_hilo_we <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall        = (r_state != S_IDLE);
  assign muldiv_start = r_start;
  assign muldiv_op    = r_md_op;
  assign hilo_we      = r_hilo_we;
`else
  assign stall        = 1'b0;
  assign muldiv_start = 1'b0;
  assign muldiv_op    = 2'b00;
  assign hilo_we      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_control_pipe
//
// Self-checking bench for alu_control_pipe (MULDIV_LAT = 3). The reference
// model is table driven. Mult/div timing is tracked as cycle indices relative
// to the cycle in which the request was accepted. Directed sequences come
// first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_alu_control_pipe;

  localparam int CTRL_W = 4;
  localparam int LAT    = 3;
`ifdef ALU_CTRL_MULDIV_EN
  localparam bit MD_EN  = 1'b1;
`else
  localparam bit MD_EN  = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_in;
  logic [1:0]        aluop;
  logic [5:0]        funct;
  logic [5:0]        opcode;
  logic [CTRL_W-1:0] control;
  logic              shamt_sel;
  logic              illegal;
  logic              valid_out;
  logic              stall;
  logic              muldiv_start;
  logic [1:0]        muldiv_op;
  logic              hilo_we;

  alu_control_pipe #(.CTRL_W(CTRL_W), .MULDIV_LAT(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .aluop        (aluop),
    .funct        (funct),
    .opcode       (opcode),
    .control      (control),
    .shamt_sel    (shamt_sel),
    .illegal      (illegal),
    .valid_out    (valid_out),
    .stall        (stall),
    .muldiv_start (muldiv_start),
    .muldiv_op    (muldiv_op),
    .hilo_we      (hilo_we)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference tables: -1 marks an unsupported code.
  // ---------------------------------------------------------------------------
  int rt_ctrl [64];
  bit rt_sh   [64];
  int it_ctrl [64];

  initial begin
    for (int i = 0; i < 64; i++) begin
      rt_ctrl[i] = -1;
      rt_sh[i]   = 1'b0;
      it_ctrl[i] = -1;
    end
    rt_ctrl[6'b100000] = 2;  rt_ctrl[6'b100001] = 2;
    rt_ctrl[6'b100010] = 6;  rt_ctrl[6'b100011] = 6;
    rt_ctrl[6'b100100] = 0;  rt_ctrl[6'b100101] = 1;
    rt_ctrl[6'b100110] = 3;  rt_ctrl[6'b100111] = 12;
    rt_ctrl[6'b101010] = 7;  rt_ctrl[6'b101011] = 8;
    rt_ctrl[6'b000000] = 9;  rt_sh[6'b000000] = 1'b1;
    rt_ctrl[6'b000010] = 10; rt_sh[6'b000010] = 1'b1;
    rt_ctrl[6'b000011] = 11; rt_sh[6'b000011] = 1'b1;
    rt_ctrl[6'b000100] = 9;
    rt_ctrl[6'b000110] = 10;
    rt_ctrl[6'b000111] = 11;
    it_ctrl[6'b001000] = 2;  it_ctrl[6'b001001] = 2;
    it_ctrl[6'b001100] = 0;  it_ctrl[6'b001101] = 1;
    it_ctrl[6'b001110] = 3;  it_ctrl[6'b001010] = 7;
    it_ctrl[6'b001011] = 8;
  end

  function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                     input logic [5:0] oc, output int c,
                                     output bit sh, output bit ill, output bit md);
    c = 0; sh = 1'b0; ill = 1'b0; md = 1'b0;
    case (op)
      2'd0: c = 2;
      2'd1: c = 6;
      2'd2: begin
        if (f >= 6'd24 && f <= 6'd27) begin
          if (MD_EN) md = 1'b1;
          else       ill = 1'b1;
        end else if (rt_ctrl[f] < 0) begin
          ill = 1'b1;
        end else begin
          c  = rt_ctrl[f];
          sh = rt_sh[f];
        end
      end
      default: begin
        if (it_ctrl[oc] < 0) ill = 1'b1;
        else                 c = it_ctrl[oc];
      end
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Model state
  // ---------------------------------------------------------------------------
  int cyc = 0;
  int m_ctrl;
  bit m_sh, m_ill, m_vout;
  bit md_active = 1'b0;  // a mult/div was accepted and not cancelled by reset
  int md_t      = 0;     // cycle in which that mult/div was accepted
  logic [1:0] md_op;

  function automatic bit exp_stall(input int k);
    return md_active && (k >= md_t + 1) && (k <= md_t + LAT + 1);
  endfunction

  // Drive one cycle of inputs, advance one clock, then check every output.
  task automatic step(input bit rst, input bit v, input logic [1:0] op,
                      input logic [5:0] f, input logic [5:0] oc);
    int c;
    bit sh, ill, md, stall_now;
    reset = rst; valid_in = v; aluop = op; funct = f; opcode = oc;
    stall_now = exp_stall(cyc);
    if (rst) begin
      m_ctrl = 0; m_sh = 1'b0; m_ill = 1'b0; m_vout = 1'b0;
      md_active = 1'b0;
    end else if (v && !stall_now) begin
      ref_decode(op, f, oc, c, sh, ill, md);
      m_ctrl = c; m_sh = sh; m_ill = ill; m_vout = 1'b1;
      if (md) begin
        md_active = 1'b1;
        md_t      = cyc;
        md_op     = f[1:0];
      end
    end else begin
      m_vout = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    check("control",      32'(control),      32'(m_ctrl));
    check("shamt_sel",    32'(shamt_sel),    32'(m_sh));
    check("illegal",      32'(illegal),      32'(m_ill));
    check("valid_out",    32'(valid_out),    32'(m_vout));
    check("stall",        32'(stall),        32'(exp_stall(cyc)));
    check("muldiv_start", 32'(muldiv_start), 32'(md_active && cyc == md_t + 1));
    check("hilo_we",      32'(hilo_we),      32'(md_active && cyc == md_t + LAT + 1));
`ifdef ALU_CTRL_MULDIV_EN
    if (md_active && cyc == md_t + 1) check("muldiv_op", 32'(muldiv_op), 32'(md_op));
`else
    check("muldiv_op", 32'(muldiv_op), 32'(0));
`endif
  endtask

  // Pool of R-type functs: all supported codes, mult/div codes, some illegal ones.
  logic [5:0] f_pool [24] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                              6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                              6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110,
                              6'b000111, 6'b011000, 6'b011001, 6'b011010, 6'b011011,
                              6'b111111, 6'b000001, 6'b101100, 6'b011100};
  logic [5:0] o_pool [10] = '{6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110,
                              6'b001010, 6'b001011, 6'b001111, 6'b000000, 6'b100011};

  initial begin
    reset = 1'b1; valid_in = 1'b0; aluop = 2'b00; funct = 6'd0; opcode = 6'd0;

    // Reset state
    step(1, 0, 2'b00, 6'd0, 6'd0);
    step(1, 0, 2'b00, 6'd0, 6'd0);

    // SUB, then idle: valid_out drops, control holds
    step(0, 1, 2'b10, 6'b100010, 6'd0);
    step(0, 0, 2'b10, 6'b100010, 6'd0);

    // Shifts with and without shamt, then an I-type XOR
    step(0, 1, 2'b10, 6'b000011, 6'd0);
    step(0, 1, 2'b10, 6'b000111, 6'd0);
    step(0, 1, 2'b11, 6'd0, 6'b001110);

    // Illegal funct, then a load/store ADD
    step(0, 1, 2'b10, 6'b111111, 6'd0);
    step(0, 1, 2'b00, 6'd0, 6'd0);

    // div, then an ADD held on the inputs until the interlock drops
    step(0, 1, 2'b10, 6'b011010, 6'd0);
    for (int i = 0; i < LAT + 3; i++) step(0, 1, 2'b00, 6'd0, 6'd0);

    // Back-to-back mult/div: the second one waits for stall to drop
    step(0, 1, 2'b10, 6'b011001, 6'd0);
    for (int i = 0; i < LAT + 3; i++) step(0, 1, 2'b10, 6'b011011, 6'd0);
    for (int i = 0; i < LAT + 2; i++) step(0, 0, 2'b00, 6'd0, 6'd0);

    // mult, then reset in the middle of BUSY
    step(0, 1, 2'b10, 6'b011000, 6'd0);
    step(0, 0, 2'b00, 6'd0, 6'd0);
    step(1, 0, 2'b00, 6'd0, 6'd0);
    for (int i = 0; i < LAT + 2; i++) step(0, 0, 2'b00, 6'd0, 6'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [1:0] op;
      logic [5:0] f, oc;
      op = 2'($urandom_range(0, 3));
      f  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : f_pool[$urandom_range(0, 23)];
      oc = ($urandom_range(0, 3) == 0) ? 6'($urandom) : o_pool[$urandom_range(0, 9)];
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, op, f, oc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
